// File: rtl/muldiv_if.sv
// muldiv_if: issue and write-back bundle between the operand-read stage,
// the iterative multiply/divide unit and the register-file write port.
//   start/op/opa/opb/rd : operation request (issuer -> unit)
//   busy                : unit occupied, issuer must stall (unit -> issuer)
//   wb_valid/wb_reg/wb_data : write-back request (unit -> write port)
//   wb_ready            : write port accepts the request (write port -> unit)
// modport master: the issuer / write-port side. modport slave: the unit.
interface muldiv_if #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 32
);
  localparam int ADDR = $clog2(DEPTH);

  logic             start;
  logic [1:0]       op;
  logic [WIDTH-1:0] opa;
  logic [WIDTH-1:0] opb;
  logic [ADDR-1:0]  rd;
  logic             busy;
  logic             wb_valid;
  logic [ADDR-1:0]  wb_reg;
  logic [WIDTH-1:0] wb_data;
  logic             wb_ready;

  modport master (
    output start, op, opa, opb, rd, wb_ready,
    input  busy, wb_valid, wb_reg, wb_data
  );

  modport slave (
    input  start, op, opa, opb, rd, wb_ready,
    output busy, wb_valid, wb_reg, wb_data
  );
endinterface

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative unsigned multiply/divide unit, one bit per cycle.
// Ports:
//   clk    : rising-edge clock
//   reset  : synchronous active-high reset, dominant on every edge
//   bus    : muldiv_if.slave (request, busy, write-back handshake)
// Ops: 00 MUL (low half), 01 MULHU (high half), 10 DIVU (quotient),
//      11 REMU (remainder). Divide by zero gives all-ones / dividend.
// Accept at edge N -> wb_valid from edge N+WIDTH+1. rd==0 retires silently.
module muldiv_unit #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 32
) (
  input  logic     clk,
  input  logic     reset,
  muldiv_if.slave  bus
);
  localparam int ADDR = $clog2(DEPTH);
  localparam int CW   = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } state_t;

  state_t             state_r;
  logic [1:0]         op_r;
  logic [WIDTH-1:0]   mcand_r;
  logic [WIDTH-1:0]   dvsr_r;
  logic [WIDTH-1:0]   quo_r;
  logic [WIDTH-1:0]   rem_r;
  logic [2*WIDTH-1:0] prod_r;
  logic [ADDR-1:0]    rd_r;
  logic [CW-1:0]      cnt_r;
  logic               busy_r;
  logic               wb_valid_r;
  logic [ADDR-1:0]    wb_reg_r;
  logic [WIDTH-1:0]   wb_data_r;

  logic [WIDTH:0]     sum_s;
  logic [2*WIDTH-1:0] prod_next_s;
  logic [WIDTH:0]     rem_shift_s;
  logic [WIDTH-1:0]   diff_s;
  logic [WIDTH-1:0]   rem_next_s;
  logic [WIDTH-1:0]   quo_next_s;
  logic [WIDTH-1:0]   result_s;

  // One shift-add step and one restoring-division step, plus result select.
  always_comb begin
    sum_s       = {1'b0, prod_r[2*WIDTH-1:WIDTH]} +
                  (prod_r[0] ? {1'b0, mcand_r} : {(WIDTH+1){1'b0}});
    prod_next_s = {sum_s, prod_r[WIDTH-1:1]};
    // The shifted partial remainder needs WIDTH+1 bits; the difference
    // always fits in WIDTH bits whenever it is kept, so only the low bits
    // are subtracted. A zero divisor always "subtracts", giving all-ones
    // quotient and a remainder that ends up equal to the dividend.
    rem_shift_s = {rem_r, quo_r[WIDTH-1]};
    diff_s      = rem_shift_s[WIDTH-1:0] - dvsr_r;
    if (rem_shift_s >= {1'b0, dvsr_r}) begin
      rem_next_s = diff_s;
      quo_next_s = {quo_r[WIDTH-2:0], 1'b1};
    end else begin
      rem_next_s = rem_shift_s[WIDTH-1:0];
      quo_next_s = {quo_r[WIDTH-2:0], 1'b0};
    end
    case (op_r)
      2'b00:   result_s = prod_r[WIDTH-1:0];
      2'b01:   result_s = prod_r[2*WIDTH-1:WIDTH];
      2'b10:   result_s = quo_r;
      2'b11:   result_s = rem_r;
      default: result_s = {WIDTH{1'b0}};
    endcase
  end

  // Control FSM with datapath registers and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r    <= IDLE;
      op_r       <= 2'b00;
      mcand_r    <= {WIDTH{1'b0}};
      dvsr_r     <= {WIDTH{1'b0}};
      quo_r      <= {WIDTH{1'b0}};
      rem_r      <= {WIDTH{1'b0}};
      prod_r     <= {(2*WIDTH){1'b0}};
      rd_r       <= {ADDR{1'b0}};
      cnt_r      <= {CW{1'b0}};
      busy_r     <= 1'b0;
      wb_valid_r <= 1'b0;
      wb_reg_r   <= {ADDR{1'b0}};
      wb_data_r  <= {WIDTH{1'b0}};
    end else begin
      case (state_r)
        IDLE: begin
          if (bus.start) begin
            op_r    <= bus.op;
            mcand_r <= bus.opa;
            dvsr_r  <= bus.opb;
            rd_r    <= bus.rd;
            prod_r  <= {{WIDTH{1'b0}}, bus.opb};
            quo_r   <= bus.opa;
            rem_r   <= {WIDTH{1'b0}};
            cnt_r   <= {CW{1'b0}};
            busy_r  <= 1'b1;
            state_r <= RUN;
          end
        end
        RUN: begin
          if (cnt_r != CW'(WIDTH)) begin
            prod_r <= prod_next_s;
            rem_r  <= rem_next_s;
            quo_r  <= quo_next_s;
            cnt_r  <= cnt_r + {{(CW-1){1'b0}}, 1'b1};
          end else if (rd_r != {ADDR{1'b0}}) begin
            wb_valid_r <= 1'b1;
            wb_reg_r   <= rd_r;
            wb_data_r  <= result_s;
            state_r    <= DONE;
          end else begin
            // Writes to register 0 are discarded: retire without a request.
            busy_r  <= 1'b0;
            state_r <= IDLE;
          end
        end
        DONE: begin
          if (bus.wb_ready) begin
            wb_valid_r <= 1'b0;
            busy_r     <= 1'b0;
            state_r    <= IDLE;
          end
        end
        default: begin
          state_r    <= IDLE;
          busy_r     <= 1'b0;
          wb_valid_r <= 1'b0;
        end
      endcase
    end
  end

  assign bus.busy     = busy_r;
  assign bus.wb_valid = wb_valid_r;
  assign bus.wb_reg   = wb_reg_r;
  assign bus.wb_data  = wb_data_r;
endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: directed self-checking bench for muldiv_unit.
module tb_muldiv_unit;
  localparam logic [1:0] OP_MUL   = 2'b00;
  localparam logic [1:0] OP_MULHU = 2'b01;
  localparam logic [1:0] OP_DIVU  = 2'b10;
  localparam logic [1:0] OP_REMU  = 2'b11;

  logic clk;
  logic reset;
  int   errors;
  int   checks;
  int   hs_count;

  muldiv_if #(.WIDTH(32), .DEPTH(32)) bus ();
  muldiv_unit #(.WIDTH(32), .DEPTH(32)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Count accepted write-back handshakes.
  always @(posedge clk) begin
    if (bus.wb_valid && bus.wb_ready) hs_count <= hs_count + 1;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Waits for wb_valid; cyc is the number of edges waited, -1 on timeout.
  task automatic wait_wb(output int cyc);
    cyc = -1;
    for (int i = 1; i <= 100; i++) begin
      step();
      if (bus.wb_valid) begin
        cyc = i;
        break;
      end
    end
  endtask

  // Issues one operation, scrambles operands after accept, waits for result.
  task automatic do_op(input logic [1:0] o, input logic [31:0] a,
                       input logic [31:0] b, input logic [4:0] r,
                       output int cyc, output logic [31:0] data,
                       output logic [4:0] rg);
    bus.op = o; bus.opa = a; bus.opb = b; bus.rd = r; bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    bus.opa = 32'hDEAD_BEEF;
    bus.opb = 32'h0000_0003;
    bus.rd  = 5'd30;
    wait_wb(cyc);
    data = bus.wb_data;
    rg   = bus.wb_reg;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    bus.start = 1'b0; bus.op = 2'b00; bus.opa = 32'd0; bus.opb = 32'd0;
    bus.rd = 5'd0; bus.wb_ready = 1'b0;
    step();
    step();
    reset = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      checks++;
      if (bus.busy !== 1'b0 || bus.wb_valid !== 1'b0 ||
          bus.wb_reg !== 5'd0 || bus.wb_data !== 32'd0) begin
        errors++;
        $display("FAIL reset_idle cycle %0d: busy=%b valid=%b reg=%0d data=%h, required 0/0/0/0",
                 i, bus.busy, bus.wb_valid, bus.wb_reg, bus.wb_data);
      end
    end
  endtask

  task automatic test_mul();
    int cyc; logic [31:0] d; logic [4:0] rg;
    bus.wb_ready = 1'b1;
    do_op(OP_MUL, 32'd7, 32'd6, 5'd3, cyc, d, rg);
    checks++;
    if (cyc !== 33) begin
      errors++; $display("FAIL mul_latency: got %0d required 33", cyc);
    end
    checks++;
    if (rg !== 5'd3) begin
      errors++; $display("FAIL mul_reg: got %0d required 3", rg);
    end
    checks++;
    if (d !== 32'd42) begin
      errors++; $display("FAIL mul_data: got %h required 0000002a", d);
    end
    checks++;
    if (bus.busy !== 1'b1) begin
      errors++; $display("FAIL mul_busy_at_valid: got %b required 1", bus.busy);
    end
    step();
    checks++;
    if (bus.busy !== 1'b0 || bus.wb_valid !== 1'b0) begin
      errors++;
      $display("FAIL mul_retire: busy=%b valid=%b required 0/0", bus.busy, bus.wb_valid);
    end
    checks++;
    if (bus.wb_data !== 32'd42 || bus.wb_reg !== 5'd3) begin
      errors++;
      $display("FAIL mul_hold_after: data=%h reg=%0d required 0000002a/3", bus.wb_data, bus.wb_reg);
    end
  endtask

  task automatic test_mulhu();
    int cyc; logic [31:0] d; logic [4:0] rg;
    bus.wb_ready = 1'b1;
    do_op(OP_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd5, cyc, d, rg);
    step();
    checks++;
    if (d !== 32'hFFFF_FFFE || rg !== 5'd5) begin
      errors++; $display("FAIL mulhu_max: data=%h reg=%0d required fffffffe/5", d, rg);
    end
    do_op(OP_MUL, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd5, cyc, d, rg);
    step();
    checks++;
    if (d !== 32'h0000_0001) begin
      errors++; $display("FAIL mul_max_low: data=%h required 00000001", d);
    end
  endtask

  task automatic test_div();
    int cyc; logic [31:0] d; logic [4:0] rg;
    bus.wb_ready = 1'b1;
    do_op(OP_DIVU, 32'd100, 32'd7, 5'd9, cyc, d, rg);
    step();
    checks++;
    if (d !== 32'd14 || rg !== 5'd9 || cyc !== 33) begin
      errors++; $display("FAIL divu_100_7: data=%h reg=%0d lat=%0d required 0000000e/9/33", d, rg, cyc);
    end
    do_op(OP_REMU, 32'd100, 32'd7, 5'd9, cyc, d, rg);
    step();
    checks++;
    if (d !== 32'd2) begin
      errors++; $display("FAIL remu_100_7: data=%h required 00000002", d);
    end
    do_op(OP_DIVU, 32'd100, 32'd0, 5'd9, cyc, d, rg);
    step();
    checks++;
    if (d !== 32'hFFFF_FFFF) begin
      errors++; $display("FAIL divu_by_zero: data=%h required ffffffff", d);
    end
    do_op(OP_REMU, 32'd100, 32'd0, 5'd9, cyc, d, rg);
    step();
    checks++;
    if (d !== 32'd100) begin
      errors++; $display("FAIL remu_by_zero: data=%h required 00000064", d);
    end
  endtask

  task automatic test_backpressure();
    int cyc; int hs0; int extra;
    bus.wb_ready = 1'b0;
    hs0 = hs_count;
    bus.op = OP_DIVU; bus.opa = 32'd1000; bus.opb = 32'd33; bus.rd = 5'd7;
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    for (int i = 0; i < 5; i++) step();
    // Start during RUN must be ignored.
    bus.op = OP_DIVU; bus.opa = 32'd9; bus.opb = 32'd3; bus.rd = 5'd8;
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    wait_wb(cyc);
    checks++;
    if (cyc < 0 || cyc + 6 !== 33) begin
      errors++; $display("FAIL bp_latency: got %0d required 33", (cyc < 0) ? -1 : cyc + 6);
    end
    for (int i = 0; i < 10; i++) begin
      checks++;
      if (bus.wb_valid !== 1'b1 || bus.wb_reg !== 5'd7 || bus.wb_data !== 32'd30) begin
        errors++;
        $display("FAIL bp_hold cycle %0d: valid=%b reg=%0d data=%h required 1/7/0000001e",
                 i, bus.wb_valid, bus.wb_reg, bus.wb_data);
      end
      bus.start = (i == 3) ? 1'b1 : 1'b0;
      step();
    end
    // Start coincident with the handshake edge must also be ignored.
    bus.wb_ready = 1'b1;
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    checks++;
    if (bus.busy !== 1'b0 || bus.wb_valid !== 1'b0) begin
      errors++;
      $display("FAIL bp_release: busy=%b valid=%b required 0/0", bus.busy, bus.wb_valid);
    end
    extra = 0;
    for (int i = 0; i < 40; i++) begin
      step();
      if (bus.busy || bus.wb_valid) extra++;
    end
    checks++;
    if (extra !== 0) begin
      errors++; $display("FAIL bp_start_ignored: active cycles %0d required 0", extra);
    end
    checks++;
    if (hs_count - hs0 !== 1) begin
      errors++; $display("FAIL bp_single_wb: writebacks %0d required 1", hs_count - hs0);
    end
  endtask

  task automatic test_rd_zero();
    int drop; int saw;
    bus.wb_ready = 1'b1;
    bus.op = OP_MUL; bus.opa = 32'd3; bus.opb = 32'd4; bus.rd = 5'd0;
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    checks++;
    if (bus.busy !== 1'b1) begin
      errors++; $display("FAIL rd0_busy_after_accept: got %b required 1", bus.busy);
    end
    drop = -1; saw = 0;
    for (int i = 1; i <= 40; i++) begin
      step();
      if (bus.wb_valid) saw = 1;
      if (drop < 0 && !bus.busy) drop = i;
    end
    checks++;
    if (saw !== 0) begin
      errors++; $display("FAIL rd0_no_wb: wb_valid seen %0d required 0", saw);
    end
    checks++;
    if (drop !== 33) begin
      errors++; $display("FAIL rd0_busy_drop: got %0d required 33", drop);
    end
  endtask

  task automatic test_reset_mid();
    int hs0; int saw;
    bus.wb_ready = 1'b1;
    hs0 = hs_count;
    bus.op = OP_DIVU; bus.opa = 32'd100; bus.opb = 32'd7; bus.rd = 5'd4;
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    for (int i = 0; i < 9; i++) step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    checks++;
    if (bus.busy !== 1'b0 || bus.wb_valid !== 1'b0) begin
      errors++;
      $display("FAIL midrst_abort: busy=%b valid=%b required 0/0", bus.busy, bus.wb_valid);
    end
    checks++;
    if (bus.wb_data !== 32'd0 || bus.wb_reg !== 5'd0) begin
      errors++;
      $display("FAIL midrst_clear: data=%h reg=%0d required 00000000/0", bus.wb_data, bus.wb_reg);
    end
    saw = 0;
    for (int i = 0; i < 40; i++) begin
      step();
      if (bus.wb_valid || bus.busy) saw++;
    end
    checks++;
    if (saw !== 0 || hs_count - hs0 !== 0) begin
      errors++;
      $display("FAIL midrst_no_wb: active=%0d writebacks=%0d required 0/0", saw, hs_count - hs0);
    end
  endtask

  initial begin
    errors = 0;
    checks = 0;
    hs_count = 0;
    test_reset();
    test_mul();
    test_mulhu();
    test_div();
    test_backpressure();
    test_rd_zero();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
